pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl_pkg.sv | 34 +++
 rtl/pipeline_mem_wait.sv | 53 +++++
 rtl/pipeline_ctrl.sv | 109 ++++++++++
 tb/tb_pipeline_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants, register bit map and FSM encodings for the pipeline controller.
package pipeline_ctrl_pkg;

  // Pipeline register count and per-register bit positions in stall/flush.
  localparam int unsigned NUM_REGS = 5;
  localparam int unsigned PC       = 0;
  localparam int unsigned IF_ID    = 1;
  localparam int unsigned ID_EX    = 2;
  localparam int unsigned EX_MEM   = 3;
  localparam int unsigned MEM_WB   = 4;

  // Register address width of the ID/EX register file ports.
  localparam int unsigned REG_ADDR_W = 5;

  // Divider latency and memory acknowledge timeout.
  localparam int unsigned DIV_CYCLES  = 32;
  localparam int unsigned MEM_TIMEOUT = 255;

  // Counter widths sized to hold DIV_CYCLES and MEM_TIMEOUT.
  localparam int unsigned DIV_CNT_W = 6;
  localparam int unsigned MEM_CNT_W = 8;

  typedef enum logic {
    M_IDLE = 1'b0,
    M_WAIT = 1'b1
  } mem_state_t;

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_RUN  = 2'd1,
    D_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/pipeline_mem_wait.sv
// Memory wait tracker: stalls on an unacknowledged access and times out after
// MEM_TIMEOUT wait cycles, reporting the timeout with a one-cycle bus_err pulse.
module pipeline_mem_wait
  import pipeline_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic mem_req,
  input  logic mem_ack,
  output logic mem_stall,
  output logic bus_err
);

  mem_state_t           state;
  logic [MEM_CNT_W-1:0] wait_cnt;
  logic                 timeout;

  // An acknowledge arriving on the limit cycle still wins over the timeout.
  assign timeout   = (state == M_WAIT) && (wait_cnt == MEM_CNT_W'(MEM_TIMEOUT)) && !mem_ack;
  assign mem_stall = mem_req && !mem_ack && !timeout;

  // Memory FSM, wait counter and registered timeout pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= M_IDLE;
      wait_cnt <= '0;
      bus_err  <= 1'b0;
    end else begin
      bus_err <= timeout;
      case (state)
        M_IDLE: begin
          wait_cnt <= '0;
          if (mem_req && !mem_ack) begin
            state <= M_WAIT;
          end
        end
        M_WAIT: begin
          if (mem_ack || timeout) begin
            state    <= M_IDLE;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + MEM_CNT_W'(1);
          end
        end
        default: begin
          state    <= M_IDLE;
          wait_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: combines memory wait, divider occupancy,
// load-use and taken-branch conditions into per-register stall/flush enables.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_rs_ren,
  input  logic                  id_rt_ren,
  input  logic [REG_ADDR_W-1:0] id_rs_raddr,
  input  logic [REG_ADDR_W-1:0] id_rt_raddr,
  input  logic                  ex_is_load,
  input  logic                  ex_is_div,
  input  logic [REG_ADDR_W-1:0] ex_wraddr,
  input  logic                  branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ack,
  output logic [NUM_REGS-1:0]   stall,
  output logic [NUM_REGS-1:0]   flush,
  output logic                  div_start,
  output logic                  div_busy,
  output logic                  bus_err
);

  div_state_t           div_state;
  logic [DIV_CNT_W-1:0] div_cnt;
  logic                 mem_stall;
  logic                 load_use;
  logic                 rs_hit;
  logic                 rt_hit;

  pipeline_mem_wait u_mem_wait (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_ack   (mem_ack),
    .mem_stall (mem_stall),
    .bus_err   (bus_err)
  );

  // Register 0 is hardwired, so a load targeting it never creates a hazard.
  assign rs_hit   = id_rs_ren && (id_rs_raddr == ex_wraddr);
  assign rt_hit   = id_rt_ren && (id_rt_raddr == ex_wraddr);
  assign load_use = ex_is_load && (ex_wraddr != '0) && (rs_hit || rt_hit);

  // Busy already in the launch cycle so the divide is held in EX immediately.
  assign div_busy = !rst && ((div_state == D_RUN) || ((div_state == D_IDLE) && ex_is_div));

  // Divide sequencer; keeps counting even while memory wait freezes the pipe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_state <= D_IDLE;
      div_cnt   <= '0;
      div_start <= 1'b0;
    end else begin
      div_start <= 1'b0;
      case (div_state)
        D_IDLE: begin
          if (ex_is_div) begin
            div_start <= 1'b1;
            div_cnt   <= DIV_CNT_W'(DIV_CYCLES);
            div_state <= D_RUN;
          end
        end
        D_RUN: begin
          div_cnt <= div_cnt - DIV_CNT_W'(1);
          if (div_cnt == DIV_CNT_W'(1)) begin
            div_state <= D_DONE;
          end
        end
        D_DONE: begin
          div_state <= D_IDLE;
        end
        default: begin
          div_state <= D_IDLE;
          div_cnt   <= '0;
        end
      endcase
    end
  end

  // Priority resolution: the winning condition alone defines stall and flush.
  always_comb begin
    stall = '0;
    flush = '0;
    if (rst) begin
      stall = '0;
      flush = '0;
    end else if (mem_stall) begin
      stall[PC]     = 1'b1;
      stall[IF_ID]  = 1'b1;
      stall[ID_EX]  = 1'b1;
      stall[EX_MEM] = 1'b1;
      flush[MEM_WB] = 1'b1;
    end else if (div_busy) begin
      stall[PC]     = 1'b1;
      stall[IF_ID]  = 1'b1;
      stall[ID_EX]  = 1'b1;
      flush[EX_MEM] = 1'b1;
    end else if (load_use) begin
      stall[PC]     = 1'b1;
      stall[IF_ID]  = 1'b1;
      flush[ID_EX]  = 1'b1;
    end else if (branch_taken) begin
      flush[IF_ID]  = 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_pipeline_ctrl;

  logic       clk;
  logic       rst;
  logic       id_rs_ren, id_rt_ren;
  logic [4:0] id_rs_raddr, id_rt_raddr, ex_wraddr;
  logic       ex_is_load, ex_is_div, branch_taken, mem_req, mem_ack;
  logic [4:0] stall, flush;
  logic       div_start, div_busy, bus_err;

  int n_pass  = 0;
  int n_total = 0;

  // Model state: remaining divider run cycles, one-cycle done phase,
  // age of the outstanding memory access, and expected registered pulses.
  int m_div_left  = 0;
  bit m_div_done  = 0;
  int m_age       = 0;
  bit m_exp_start = 0;
  bit m_exp_err   = 0;

  pipeline_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs_ren    (id_rs_ren),
    .id_rt_ren    (id_rt_ren),
    .id_rs_raddr  (id_rs_raddr),
    .id_rt_raddr  (id_rt_raddr),
    .ex_is_load   (ex_is_load),
    .ex_is_div    (ex_is_div),
    .ex_wraddr    (ex_wraddr),
    .branch_taken (branch_taken),
    .mem_req      (mem_req),
    .mem_ack      (mem_ack),
    .stall        (stall),
    .flush        (flush),
    .div_start    (div_start),
    .div_busy     (div_busy),
    .bus_err      (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_inputs();
    id_rs_ren = 0; id_rt_ren = 0; id_rs_raddr = 0; id_rt_raddr = 0;
    ex_is_load = 0; ex_is_div = 0; ex_wraddr = 0; branch_taken = 0;
    mem_req = 0; mem_ack = 0;
  endtask

  // Expected {stall, flush} for the current inputs and model state.
  function automatic logic [9:0] model_sf();
    logic [4:0] s, f;
    logic timeout, memw, busy, lu;
    s = 0; f = 0;
    timeout = (m_age == 256) && !mem_ack;
    memw    = mem_req && !mem_ack && !timeout;
    busy    = (m_div_left > 0) || (!m_div_done && ex_is_div);
    lu      = ex_is_load && (ex_wraddr != 0) &&
              ((id_rs_ren && id_rs_raddr == ex_wraddr) || (id_rt_ren && id_rt_raddr == ex_wraddr));
    if (rst) begin
      s = 0; f = 0;
    end else if (memw) begin
      s = 5'b01111; f = 5'b10000;
    end else if (busy) begin
      s = 5'b00111; f = 5'b01000;
    end else if (lu) begin
      s = 5'b00011; f = 5'b00100;
    end else if (branch_taken) begin
      f = 5'b00010;
    end
    return {s, f};
  endfunction

  function automatic logic model_busy();
    return !rst && ((m_div_left > 0) || (!m_div_done && ex_is_div));
  endfunction

  // Advance the model by one clock using the current inputs, then wait for the next negedge.
  task automatic tick();
    bit start;
    if (rst) begin
      m_div_left = 0; m_div_done = 0; m_age = 0; m_exp_start = 0; m_exp_err = 0;
    end else begin
      m_exp_err = (m_age == 256) && !mem_ack;
      start     = !m_div_done && (m_div_left == 0) && ex_is_div;
      m_exp_start = start;
      if (m_age > 0) begin
        if (mem_ack || m_age == 256) m_age = 0;
        else m_age++;
      end else if (mem_req && !mem_ack) begin
        m_age = 1;
      end
      if (m_div_done) m_div_done = 0;
      else if (m_div_left > 0) begin
        m_div_left--;
        if (m_div_left == 0) m_div_done = 1;
      end else if (start) m_div_left = 32;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    ex_is_div = 1; mem_req = 1; branch_taken = 1;
    ex_is_load = 1; ex_wraddr = 5'd3; id_rs_ren = 1; id_rs_raddr = 5'd3;
    #2;
    n_total++; if (stall !== 5'b0) $display("FAIL reset_stall: got %b want 00000", stall); else n_pass++;
    n_total++; if (flush !== 5'b0) $display("FAIL reset_flush: got %b want 00000", flush); else n_pass++;
    n_total++; if (div_start !== 1'b0) $display("FAIL reset_div_start: got %b want 0", div_start); else n_pass++;
    n_total++; if (div_busy !== 1'b0) $display("FAIL reset_div_busy: got %b want 0", div_busy); else n_pass++;
    n_total++; if (bus_err !== 1'b0) $display("FAIL reset_bus_err: got %b want 0", bus_err); else n_pass++;
    tick();
    tick();
    clear_inputs();
    rst = 0;
    #1;
    n_total++; if (stall !== 5'b0 || flush !== 5'b0) $display("FAIL post_reset_idle: got %b/%b want 00000/00000", stall, flush); else n_pass++;
    tick();
  endtask

  task automatic test_load_use();
    clear_inputs();
    ex_is_load = 1; ex_wraddr = 5'd5; id_rs_ren = 1; id_rs_raddr = 5'd5;
    #1;
    n_total++; if (stall !== 5'b00011 || flush !== 5'b00100) $display("FAIL load_use_rs: got %b/%b want 00011/00100", stall, flush); else n_pass++;
    tick();
    ex_wraddr = 5'd0; id_rs_raddr = 5'd0;
    #1;
    n_total++; if (stall !== 5'b0 || flush !== 5'b0) $display("FAIL load_use_r0: got %b/%b want 00000/00000", stall, flush); else n_pass++;
    tick();
    ex_wraddr = 5'd9; id_rs_ren = 0; id_rt_ren = 1; id_rt_raddr = 5'd9; branch_taken = 1;
    #1;
    n_total++; if (stall !== 5'b00011 || flush !== 5'b00100) $display("FAIL load_use_rt_branch: got %b/%b want 00011/00100", stall, flush); else n_pass++;
    tick();
    id_rt_ren = 0;
    #1;
    n_total++; if (stall !== 5'b0 || flush !== 5'b00010) $display("FAIL branch_only: got %b/%b want 00000/00010", stall, flush); else n_pass++;
    tick();
    clear_inputs();
  endtask

  task automatic test_divide();
    int busy_cycles = 0;
    int starts = 0;
    clear_inputs();
    ex_is_div = 1;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (div_start === 1'b1) starts++;
      if (stall === 5'b0) break;
      if (stall === 5'b00111 && flush === 5'b01000 && div_busy === 1'b1) busy_cycles++;
      tick();
    end
    n_total++; if (busy_cycles != 33) $display("FAIL div_busy_cycles: got %0d want 33", busy_cycles); else n_pass++;
    n_total++; if (starts != 1) $display("FAIL div_start_count: got %0d want 1", starts); else n_pass++;
    n_total++; if (flush !== 5'b0 || div_busy !== 1'b0) $display("FAIL div_done_release: got flush %b busy %b want 00000/0", flush, div_busy); else n_pass++;
    tick();
    ex_is_div = 0;
    #1;
    n_total++; if (div_start !== 1'b0 || stall !== 5'b0) $display("FAIL div_after_done: got start %b stall %b want 0/00000", div_start, stall); else n_pass++;
    tick();
  endtask

  task automatic test_mem_wait();
    bit err_seen = 0;
    clear_inputs();
    mem_req = 1; mem_ack = 1;
    #1;
    n_total++; if (stall !== 5'b0 || flush !== 5'b0) $display("FAIL mem_ack_same_cycle: got %b/%b want 00000/00000", stall, flush); else n_pass++;
    tick();
    mem_ack = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (bus_err === 1'b1) err_seen = 1;
      n_total++; if (stall !== 5'b01111 || flush !== 5'b10000) $display("FAIL mem_wait_c%0d: got %b/%b want 01111/10000", c, stall, flush); else n_pass++;
      tick();
    end
    mem_ack = 1;
    #1;
    if (bus_err === 1'b1) err_seen = 1;
    n_total++; if (stall !== 5'b0 || flush !== 5'b0) $display("FAIL mem_ack_release: got %b/%b want 00000/00000", stall, flush); else n_pass++;
    tick();
    clear_inputs();
    #1;
    if (bus_err === 1'b1) err_seen = 1;
    tick();
    #1;
    if (bus_err === 1'b1) err_seen = 1;
    n_total++; if (err_seen) $display("FAIL mem_wait_bus_err: got 1 want 0"); else n_pass++;
    tick();
  endtask

  task automatic test_timeout();
    int n = 0;
    bit early_err = 0;
    clear_inputs();
    mem_req = 1;
    for (int c = 0; c < 400; c++) begin
      #1;
      if (stall !== 5'b01111) break;
      if (bus_err === 1'b1) early_err = 1;
      n++;
      tick();
    end
    n_total++; if (n != 256) $display("FAIL timeout_stall_cycles: got %0d want 256", n); else n_pass++;
    n_total++; if (stall !== 5'b0 || flush !== 5'b0) $display("FAIL timeout_drop: got %b/%b want 00000/00000", stall, flush); else n_pass++;
    n_total++; if (early_err || bus_err !== 1'b0) $display("FAIL timeout_early_err: got %b want 0", bus_err); else n_pass++;
    tick();
    mem_req = 0;
    #1;
    n_total++; if (bus_err !== 1'b1) $display("FAIL timeout_bus_err: got %b want 1", bus_err); else n_pass++;
    tick();
    #1;
    n_total++; if (bus_err !== 1'b0) $display("FAIL timeout_bus_err_pulse: got %b want 0", bus_err); else n_pass++;
    tick();
  endtask

  task automatic test_overlap();
    int busy_cycles = 0;
    clear_inputs();
    ex_is_div = 1;
    for (int c = 0; c < 80; c++) begin
      mem_req      = (c >= 4 && c <= 10);
      mem_ack      = (c == 10);
      branch_taken = (c >= 4 && c <= 10);
      #1;
      if (c >= 4 && c <= 9) begin
        n_total++; if (stall !== 5'b01111 || flush !== 5'b10000) $display("FAIL overlap_mem_c%0d: got %b/%b want 01111/10000", c, stall, flush); else n_pass++;
      end
      if (c == 10) begin
        n_total++; if (stall !== 5'b00111 || flush !== 5'b01000) $display("FAIL overlap_div_branch: got %b/%b want 00111/01000", stall, flush); else n_pass++;
      end
      if (stall === 5'b0) break;
      busy_cycles++;
      tick();
    end
    n_total++; if (busy_cycles != 33) $display("FAIL overlap_div_expiry: got %0d want 33", busy_cycles); else n_pass++;
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid_div();
    bit late_start = 0;
    clear_inputs();
    ex_is_div = 1;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (m_div_left == 10) break;
    end
    n_total++; if (div_busy !== 1'b1) $display("FAIL mid_div_busy: got %b want 1", div_busy); else n_pass++;
    rst = 1;
    #1;
    n_total++; if (stall !== 5'b0 || flush !== 5'b0) $display("FAIL mid_div_reset_sf: got %b/%b want 00000/00000", stall, flush); else n_pass++;
    n_total++; if (div_busy !== 1'b0 || div_start !== 1'b0 || bus_err !== 1'b0) $display("FAIL mid_div_reset_pulses: got busy %b start %b err %b want 0/0/0", div_busy, div_start, bus_err); else n_pass++;
    tick();
    tick();
    ex_is_div = 0;
    rst = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (div_start !== 1'b0 || div_busy !== 1'b0 || stall !== 5'b0) late_start = 1;
      tick();
    end
    n_total++; if (late_start) $display("FAIL mid_div_after_release: got activity want none"); else n_pass++;
  endtask

  task automatic test_random();
    logic [9:0] sf;
    clear_inputs();
    for (int c = 0; c < 3000; c++) begin
      id_rs_ren    = 1'($urandom % 2);
      id_rt_ren    = 1'($urandom % 2);
      id_rs_raddr  = 5'($urandom_range(0, 3));
      id_rt_raddr  = 5'($urandom_range(0, 3));
      ex_wraddr    = 5'($urandom_range(0, 3));
      ex_is_load   = 1'($urandom % 2);
      ex_is_div    = ($urandom % 16) == 0;
      branch_taken = 1'($urandom % 2);
      mem_req      = ($urandom % 3) == 0;
      mem_ack      = ($urandom % 4) != 0;
      #1;
      sf = model_sf();
      n_total++; if (stall !== sf[9:5]) $display("FAIL rand_stall c%0d: got %b want %b", c, stall, sf[9:5]); else n_pass++;
      n_total++; if (flush !== sf[4:0]) $display("FAIL rand_flush c%0d: got %b want %b", c, flush, sf[4:0]); else n_pass++;
      n_total++; if (div_busy !== model_busy()) $display("FAIL rand_div_busy c%0d: got %b want %b", c, div_busy, model_busy()); else n_pass++;
      n_total++; if (div_start !== m_exp_start) $display("FAIL rand_div_start c%0d: got %b want %b", c, div_start, m_exp_start); else n_pass++;
      n_total++; if (bus_err !== m_exp_err) $display("FAIL rand_bus_err c%0d: got %b want %b", c, bus_err, m_exp_err); else n_pass++;
      n_total++; if ((stall & flush) !== 5'b0) $display("FAIL rand_exclusive c%0d: got %b want 00000", c, stall & flush); else n_pass++;
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_divide();
    test_mem_wait();
    test_timeout();
    test_overlap();
    test_reset_mid_div();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
